// File: rtl/prog_sequencer_if.sv
// Instruction-memory and cpu handshake bundle between prog_sequencer and its neighbours.
interface prog_sequencer_if #(parameter int ADDR_W = 8);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_dout;
    logic [15:0]       cpu_in;
    logic              cpu_load;
    logic              cpu_s;
    logic              cpu_w;
    logic [15:0]       cpu_out;
    logic              cpu_N;
    logic              cpu_V;
    logic              cpu_Z;

    modport master (output mem_addr, mem_rd, cpu_in, cpu_load, cpu_s,
                    input  mem_dout, cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z);
    modport slave  (input  mem_addr, mem_rd, cpu_in, cpu_load, cpu_s,
                    output mem_dout, cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z);
endinterface

// File: rtl/prog_sequencer.sv
// Fetches instructions from a synchronous memory, hands them to the cpu one at a time,
// waits on the cpu_w handshake and captures each result until the program ends.
module prog_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int WTIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   last_addr,
    prog_sequencer_if.master    bus,
    output logic [15:0]         result,
    output logic [2:0]          flags,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W:0]     instr_count,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_FETCH = 4'd1;
    localparam logic [3:0] S_MWAIT = 4'd2;
    localparam logic [3:0] S_LOAD  = 4'd3;
    localparam logic [3:0] S_GO    = 4'd4;
    localparam logic [3:0] S_WLO   = 4'd5;
    localparam logic [3:0] S_WHI   = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;

    localparam int WCNT_W = (WTIMEOUT < 4) ? 3 : $clog2(WTIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WLO_LAST = WCNT_W'(3);
    localparam logic [WCNT_W-1:0] WHI_LAST = WCNT_W'(WTIMEOUT - 1);

    logic [3:0]        state_r;
    logic [3:0]        state_nxt_s;
    logic              accept_s;
    logic              finish_s;
    logic [15:0]       ir_r;
    logic [ADDR_W-1:0] last_q_r;
    logic              stop_req_r;
    logic [WCNT_W-1:0] wcnt_r;
    logic              mem_rd_r;
    logic              cpu_load_r;

    assign finish_s     = (pc == last_q_r) || stop_req_r || stop;
    assign bus.mem_addr = pc;
    assign bus.mem_rd   = mem_rd_r;
    assign bus.cpu_in   = ir_r;
    assign bus.cpu_load = cpu_load_r;
    // cpu_s must react in the same cycle cpu_w is first seen high in GO
    assign bus.cpu_s    = (state_r == S_GO) && bus.cpu_w;

    // Next-state decode; accept_s marks a start honoured in IDLE, DONE or ERR.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt_s = S_FETCH;
                    accept_s    = 1'b1;
                end else if (state_r == S_DONE) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_FETCH: state_nxt_s = S_MWAIT;
            S_MWAIT: state_nxt_s = S_LOAD;
            S_LOAD:  state_nxt_s = S_GO;
            S_GO: begin
                if (bus.cpu_w) begin
                    state_nxt_s = S_WLO;
                end else begin
                    state_nxt_s = S_GO;
                end
            end
            S_WLO: begin
                if (!bus.cpu_w) begin
                    state_nxt_s = S_WHI;
                end else if (wcnt_r == WLO_LAST) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_WLO;
                end
            end
            S_WHI: begin
                if (bus.cpu_w) begin
                    state_nxt_s = finish_s ? S_DONE : S_FETCH;
                end else if (wcnt_r == WHI_LAST) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_WHI;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            ir_r        <= 16'h0000;
            last_q_r    <= {ADDR_W{1'b0}};
            stop_req_r  <= 1'b0;
            wcnt_r      <= {WCNT_W{1'b0}};
            mem_rd_r    <= 1'b0;
            cpu_load_r  <= 1'b0;
            result      <= 16'h0000;
            flags       <= 3'b000;
            pc          <= {ADDR_W{1'b0}};
            instr_count <= {(ADDR_W+1){1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mem_rd_r   <= (state_nxt_s == S_FETCH);
            cpu_load_r <= (state_nxt_s == S_LOAD);
            busy       <= !((state_nxt_s == S_IDLE) || (state_nxt_s == S_DONE) ||
                            (state_nxt_s == S_ERR));
            done       <= (state_nxt_s == S_DONE);
            err        <= (state_nxt_s == S_ERR);

            if (accept_s) begin
                pc          <= {ADDR_W{1'b0}};
                instr_count <= {(ADDR_W+1){1'b0}};
                stop_req_r  <= 1'b0;
                last_q_r    <= last_addr;
            end else if (busy && stop) begin
                stop_req_r <= 1'b1;
            end

            if (state_r == S_MWAIT) begin
                ir_r <= bus.mem_dout;
            end

            // one counter serves both wait states; it restarts on every state change
            if ((state_nxt_s == state_r) && ((state_r == S_WLO) || (state_r == S_WHI))) begin
                wcnt_r <= wcnt_r + 1'b1;
            end else begin
                wcnt_r <= {WCNT_W{1'b0}};
            end

            if ((state_r == S_WHI) && bus.cpu_w) begin
                result      <= bus.cpu_out;
                flags       <= {bus.cpu_N, bus.cpu_V, bus.cpu_Z};
                instr_count <= instr_count + 1'b1;
                if (state_nxt_s == S_FETCH) begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end
endmodule
